bin_to_bcd: RTL and testbench
=============================

BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter BIN_W, default 16: width of the binary input.
REQ-002 Parameter DIGITS, default 5: number of BCD digits produced (4*DIGITS output bits).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to convert bin_in; sampled only in IDLE.
REQ-006 bin_in  input  BIN_W  unsigned binary value (e.g. DAC code or scaled mV).
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when bcd_out and blank carry a new result.
REQ-009 bcd_out  output  4*DIGITS  packed BCD; [19:16] is the most significant digit; drives the 20-bit digit-scan multiplexer input directly.
REQ-010 blank  output  DIGITS  bit i high means digit i (bcd_out[4i+3:4i]) is a leading zero to be blanked.

Function
REQ-011 FSM states IDLE and SHIFT only; reset state IDLE.
REQ-012 IDLE, start=1 at edge k: latch bin_in into shift register, clear BCD scratch to 0, iteration counter to 0, busy to 1, state to SHIFT.
REQ-013 SHIFT, each edge: every scratch digit >= 5 gets +3 (4-bit, no carry out), then {scratch, shift register} shifts left 1; counter increments.
REQ-014 Iteration count is exactly BIN_W; the BIN_W-th iteration at edge k+BIN_W writes the final scratch to bcd_out, updates blank, sets done=1, busy=0, state IDLE.
REQ-015 Latency: start sampled at edge k -> done high during cycle after edge k+16 (default widths); throughput one result per 17 cycles.
REQ-016 done is high for exactly one cycle; busy and done are never both high.
REQ-017 start while busy=1 is ignored; no queuing; bin_in changes during SHIFT have no effect.
REQ-018 start in the cycle where done=1 (state IDLE) is accepted; back-to-back conversions allowed.
REQ-019 bcd_out and blank hold the previous result until the next done; never show partial results.
REQ-020 blank: digit i blanked iff it and all more significant digits are 0; digit 0 never blanked (value 0 displays "0").
REQ-021 Input range 0..65535 always fits 5 digits; no overflow output; non-default parameters require 10^DIGITS > 2^BIN_W-1, enforced by elaboration check.

Reset
REQ-022 rst=1 at any edge, including mid-conversion: state IDLE, busy=0, done=0, bcd_out=0, blank=5'b11110, counter=0; the aborted conversion produces no done.
REQ-023 start asserted together with rst is ignored.

Structure
REQ-024 Shared package/include holds BIN_W, DIGITS defaults, state encoding (IDLE=0, SHIFT=1) and counter width clog2(BIN_W+1).
REQ-025 One combinational sub-module bcd_add3 (4-bit in, 4-bit out, +3 if >=5) instantiated DIGITS times via generate.
REQ-026 Single clock domain; no derived clocks; no latches; all outputs registered.

Verification
REQ-027 rst, then start with bin_in=0 -> done after 16 cycles, bcd_out=20'h00000, blank=5'b11110.
REQ-028 bin_in=65535 -> bcd_out=20'h65535, blank=5'b00000; bin_in=1234 -> 20'h01234, blank=5'b10000.
REQ-029 start with 4095, second start with 9 at cycle 5 of busy -> single done, bcd_out=20'h04095; no second done.
REQ-030 rst pulsed at cycle 8 of conversion of 500 -> busy=0, bcd_out=0, no done pulse; next start with 500 -> 20'h00500, blank=5'b11000.
REQ-031 Back-to-back: start with 10 and again in done cycle with 99 -> done at k+16 (20'h00010) and k+33 (20'h00099).
REQ-032 Random 1000 values vs reference model: bcd_out digits equal decimal digits of bin_in, blank consistent, done exactly one cycle.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_pkg
// Shared definitions for the binary-to-BCD converter: default widths, FSM
// state encoding, counter width and a small helper used by the elaboration
// range check.
// -----------------------------------------------------------------------------
package bin_to_bcd_pkg;

   localparam int BIN_W_DEF  = 16;
   localparam int DIGITS_DEF = 5;

   // Iteration counter width for the default binary width.
   localparam int CNT_W_DEF  = $clog2(BIN_W_DEF + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // 10**n as a 64-bit value; used to prove every input code fits the digits.
   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_if
// Request/result bundle of the converter.
//   start   : one-cycle conversion request (driven by master)
//   bin_in  : unsigned binary value (driven by master)
//   busy    : conversion in progress (driven by slave)
//   done    : one-cycle result-valid pulse (driven by slave)
//   bcd_out : packed BCD result, MS digit in the top nibble (driven by slave)
//   blank   : per-digit leading-zero flags (driven by slave)
// -----------------------------------------------------------------------------
interface bin_to_bcd_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic [DIGITS-1:0]     blank;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, blank
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, blank
   );
endinterface

// File: rtl/bin_to_bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
//   i_digit : 4-bit scratch digit
//   o_digit : corrected digit (4-bit, no carry out)
// -----------------------------------------------------------------------------
module bcd_add3 (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);
   assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// A start in IDLE latches bin_in; BIN_W shift iterations later the result is
// published on bcd_out/blank together with a one-cycle done pulse. Outputs
// hold the previous result while a conversion runs.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bin_to_bcd_if slave (start, bin_in, busy, done, bcd_out, blank)
// -----------------------------------------------------------------------------
module bin_to_bcd
   import bin_to_bcd_pkg::*;
#(
   parameter int BIN_W  = BIN_W_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic           clk,
   input  logic           rst,
   bin_to_bcd_if.slave    bus
);

   localparam int                CNT_W     = $clog2(BIN_W + 1);
   localparam int                BCD_W     = 4 * DIGITS;
   localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BIN_W - 1);
   // All digits but digit 0 are blanked when the displayed value is zero.
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   // Refuse to build a converter whose largest input overflows the digits.
   if (pow10(DIGITS) <= ((longint'(1) << BIN_W) - 1)) begin : g_range_err
      $error("bin_to_bcd: DIGITS too small for BIN_W");
   end

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [BIN_W-1:0]    r_sr;
   logic [BCD_W-1:0]    r_scratch;
   logic                r_busy;
   logic                r_done;
   logic [BCD_W-1:0]    r_bcd_out;
   logic [DIGITS-1:0]   r_blank;

   logic [BCD_W-1:0]       w_adj;
   logic [BCD_W+BIN_W-1:0] w_shift_cat;
   logic [BCD_W-1:0]       w_next_scratch;
   logic [BIN_W-1:0]       w_next_sr;
   logic [DIGITS-1:0]      w_next_blank;
   logic                   w_zero_above;

   // Per-digit +3 correction ahead of the shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .i_digit (r_scratch[4*g +: 4]),
         .o_digit (w_adj[4*g +: 4])
      );
   end

   assign w_shift_cat    = {w_adj, r_sr} << 1;
   assign w_next_scratch = w_shift_cat[BCD_W+BIN_W-1 -: BCD_W];
   assign w_next_sr      = w_shift_cat[BIN_W-1:0];

   // Leading-zero flags for the value that the final iteration produces:
   // a digit is blank when it and every more significant digit are zero.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      w_next_blank = '0;
      w_zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zero_above    = w_zero_above & (w_next_scratch[4*i +: 4] == 4'd0);
         w_next_blank[i] = w_zero_above;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_sr      <= '0;
         r_scratch <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bcd_out <= '0;
         r_blank   <= BLANK_RST;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_sr      <= bus.bin_in;
                  r_scratch <= '0;
                  r_cnt     <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               r_scratch <= w_next_scratch;
               r_sr      <= w_next_sr;
               r_cnt     <= r_cnt + 1'b1;
               if (r_cnt == LAST_ITER) begin
                  r_bcd_out <= w_next_scratch;
                  r_blank   <= w_next_blank;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.bcd_out = r_bcd_out;
   assign bus.blank   = r_blank;

endmodule

// File: tb/tb_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd
// Directed self-checking bench for bin_to_bcd with default widths.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd;

   localparam int BIN_W  = 16;
   localparam int DIGITS = 5;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   bit   overlap_seen = 1'b0;

   bin_to_bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap_seen = 1'b1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: decimal digits by integer division.
   function automatic logic [19:0] exp_bcd(input int v);
      logic [19:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Reference: digit i (i>0) is a leading zero iff the value is below 10**i.
   function automatic logic [4:0] exp_blank(input int v);
      logic [4:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 1; i < DIGITS; i++) begin
         p = p * 10;
         r[i] = (v < p);
      end
      return r;
   endfunction

   // Called #1 after an edge; start is sampled at the next edge.
   task automatic pulse_start(input int v);
      bus.start  = 1'b1;
      bus.bin_in = 16'(v);
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
   endtask

   task automatic wait_done(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      bus.start  = 1'b1;
      bus.bin_in = 16'd123;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
      checks++;
      if (bus.bcd_out !== 20'h00000 || bus.blank !== 5'b11110) begin
         failures++;
         $display("FAIL reset_out: bcd=%h blank=%b expected 00000 11110", bus.bcd_out, bus.blank);
      end
      bus.start = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL start_with_rst: busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_convert(input int v, input string name);
      int          n;
      bit          ok;
      logic [19:0] prev;
      prev = bus.bcd_out;
      pulse_start(v);
      repeat (7) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.bcd_out !== prev) begin
         failures++;
         $display("FAIL %s_hold: busy=%b bcd=%h expected 1 %h", name, bus.busy, bus.bcd_out, prev);
      end
      wait_done(n, ok);
      checks++;
      if (!ok || n != 9) begin
         failures++;
         $display("FAIL %s_latency: done=%b after %0d more cycles expected 9", name, ok, n);
      end
      checks++;
      if (bus.bcd_out !== exp_bcd(v) || bus.blank !== exp_blank(v)) begin
         failures++;
         $display("FAIL %s_value: bcd=%h blank=%b expected %h %b", name,
                  bus.bcd_out, bus.blank, exp_bcd(v), exp_blank(v));
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_pulse: done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
      end
   endtask

   task automatic test_ignore_start();
      int n;
      bit ok;
      bit extra;
      pulse_start(4095);
      repeat (4) @(posedge clk);
      #1;
      bus.start  = 1'b1;
      bus.bin_in = 16'd9;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      wait_done(n, ok);
      checks++;
      if (!ok || n != 11) begin
         failures++;
         $display("FAIL ignore_latency: done=%b after %0d cycles expected 11", ok, n);
      end
      checks++;
      if (bus.bcd_out !== 20'h04095 || bus.blank !== 5'b10000) begin
         failures++;
         $display("FAIL ignore_value: bcd=%h blank=%b expected 04095 10000", bus.bcd_out, bus.blank);
      end
      extra = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         failures++;
         $display("FAIL ignore_second: extra activity=1 expected 0");
      end
   endtask

   task automatic test_reset_mid();
      bit extra;
      pulse_start(500);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 20'h0 || bus.blank !== 5'b11110) begin
         failures++;
         $display("FAIL midrst_state: busy=%b done=%b bcd=%h blank=%b expected 0 0 00000 11110",
                  bus.busy, bus.done, bus.bcd_out, bus.blank);
      end
      extra = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         failures++;
         $display("FAIL midrst_nodone: done seen=1 expected 0");
      end
      test_convert(500, "after_rst");
      checks++;
      if (bus.bcd_out !== 20'h00500 || bus.blank !== 5'b11000) begin
         failures++;
         $display("FAIL after_rst_const: bcd=%h blank=%b expected 00500 11000", bus.bcd_out, bus.blank);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bit ok;
      pulse_start(10);
      wait_done(n, ok);
      checks++;
      if (!ok || n != 16 || bus.bcd_out !== 20'h00010 || bus.blank !== 5'b11100) begin
         failures++;
         $display("FAIL b2b_first: done=%b n=%0d bcd=%h blank=%b expected 1 16 00010 11100",
                  ok, n, bus.bcd_out, bus.blank);
      end
      pulse_start(99);
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", bus.busy, bus.done);
      end
      wait_done(n, ok);
      checks++;
      if (!ok || n != 16 || bus.bcd_out !== 20'h00099 || bus.blank !== 5'b11100) begin
         failures++;
         $display("FAIL b2b_second: done=%b n=%0d bcd=%h blank=%b expected 1 16 00099 11100",
                  ok, n, bus.bcd_out, bus.blank);
      end
   endtask

   task automatic test_random();
      int v;
      int bad;
      int n;
      bit ok;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         v = int'($urandom_range(65535, 0));
         pulse_start(v);
         wait_done(n, ok);
         if (!ok || n != 16 || bus.bcd_out !== exp_bcd(v) || bus.blank !== exp_blank(v)) begin
            if (bad < 5)
               $display("FAIL random_value: in=%0d n=%0d bcd=%h blank=%b expected 16 %h %b",
                        v, n, bus.bcd_out, bus.blank, exp_bcd(v), exp_blank(v));
            bad++;
         end
         @(posedge clk);
         #1;
         if (bus.done !== 1'b0) begin
            if (bad < 5) $display("FAIL random_pulse: in=%0d done=%b expected 0", v, bus.done);
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL random_total: bad=%0d expected 0", bad);
      end
   endtask

   task automatic test_overlap();
      checks++;
      if (overlap_seen) begin
         failures++;
         $display("FAIL busy_done_overlap: seen=1 expected 0");
      end
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.bin_in = '0;
      rst        = 1'b1;
      test_reset();
      test_convert(0, "zero");
      test_convert(65535, "max");
      test_convert(1234, "v1234");
      test_convert(7, "v7");
      test_convert(10000, "v10000");
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_overlap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
